// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: memory, PC/IR register, execute handshake and fault signals of the fetch sequencer
interface fetch_sequencer_if;
    logic [31:0] pc_q;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        pc_write_enable;
    logic [31:0] pc_next;
    logic        ir_write_enable;
    logic [31:0] ir_data;
    logic        instr_valid;
    logic        instr_done;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        fault;
    logic [1:0]  fault_cause;

    modport master (
        input  pc_q, mem_ready, mem_rdata, mem_err, instr_done, redirect, redirect_target,
        output mem_req, mem_addr, pc_write_enable, pc_next, ir_write_enable, ir_data,
               instr_valid, fault, fault_cause
    );

    modport slave (
        output pc_q, mem_ready, mem_rdata, mem_err, instr_done, redirect, redirect_target,
        input  mem_req, mem_addr, pc_write_enable, pc_next, ir_write_enable, ir_data,
               instr_valid, fault, fault_cause
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: FETCH/EXEC/FAULT sequencer driving instruction memory, PC and IR writes, with sticky fault and retire counter
module fetch_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    fetch_sequencer_if.master bus,
    output logic [CNT_W-1:0]  retired_count
);
    typedef enum logic [1:0] {FETCH, EXEC, FAULT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fetch, in_exec, in_fault, req, fetch_ok, fetch_err, bad_tgt, redir_ok, retire;

    always_comb begin
        in_fetch  = !reset && state_q == FETCH;
        in_exec   = !reset && state_q == EXEC;
        in_fault  = !reset && state_q == FAULT;
        req       = in_fetch && bus.pc_q[1:0] == 2'd0;
        fetch_ok  = req && bus.mem_ready && !bus.mem_err;
        fetch_err = req && bus.mem_ready && bus.mem_err;
        bad_tgt   = in_exec && bus.instr_done && bus.redirect && bus.redirect_target[1:0] != 2'd0;
        redir_ok  = in_exec && bus.instr_done && bus.redirect && !bad_tgt;
        retire    = in_exec && bus.instr_done && !bad_tgt;
        state_d   = (in_fetch && !req) || fetch_err || bad_tgt ? FAULT :
                    fetch_ok ? EXEC :
                    retire ? FETCH : state_q;
        cause_d   = in_fetch && !req ? 2'd1 :
                    fetch_err ? 2'd2 :
                    bad_tgt ? 2'd3 : cause_q;
        cnt_d     = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Everything except the cause and counter is decoded combinationally; reset gates all of it to 0.
    assign bus.mem_req         = req;
    assign bus.mem_addr        = req ? bus.pc_q : 32'd0;
    assign bus.ir_write_enable = fetch_ok;
    assign bus.ir_data         = fetch_ok ? bus.mem_rdata : 32'd0;
    assign bus.pc_write_enable = fetch_ok || redir_ok;
    assign bus.pc_next         = fetch_ok ? bus.pc_q + 32'd4 : redir_ok ? bus.redirect_target : 32'd0;
    assign bus.instr_valid     = in_exec;
    assign bus.fault           = in_fault;
    assign bus.fault_cause     = reset ? 2'd0 : cause_q;
    assign retired_count       = reset ? '0 : cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            cause_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed per-cycle vectors plus a 16-instruction retire run checking the 4-bit counter wrap
module tb_fetch_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] cnt32;
    logic [3:0]  cnt4;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    fetch_sequencer_if bus ();
    fetch_sequencer_if bus4 ();

    assign bus4.pc_q            = bus.pc_q;
    assign bus4.mem_ready       = bus.mem_ready;
    assign bus4.mem_rdata       = bus.mem_rdata;
    assign bus4.mem_err         = bus.mem_err;
    assign bus4.instr_done      = bus.instr_done;
    assign bus4.redirect        = bus.redirect;
    assign bus4.redirect_target = bus.redirect_target;

    fetch_sequencer #(.CNT_W(32)) dut (.clock(clock), .reset(reset), .bus(bus), .retired_count(cnt32));
    fetch_sequencer #(.CNT_W(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4), .retired_count(cnt4));

    // ci = {reset, mem_ready, mem_err, instr_done, redirect}
    // co = {mem_req, ir_write_enable, pc_write_enable, instr_valid, fault}
    typedef struct {
        logic [4:0]  ci;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] tgt;
        logic [4:0]  co;
        logic [31:0] addr;
        logic [31:0] ird;
        logic [31:0] pcn;
        logic [1:0]  cause;
        logic [31:0] cnt;
    } vec_t;

    vec_t v[$];

    task automatic drive(input logic [4:0] ci, input logic [31:0] pc, input logic [31:0] rdata, input logic [31:0] tgt);
        @(negedge clock);
        {reset, bus.mem_ready, bus.mem_err, bus.instr_done, bus.redirect} = ci;
        bus.pc_q            = pc;
        bus.mem_rdata       = rdata;
        bus.redirect_target = tgt;
        #1;
    endtask

    task automatic check(input string name, input logic [167:0] act, input logic [167:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        logic [167:0] act, exp;
        logic [31:0]  exp_cnt;
        v.push_back('{5'b11000, 32'h0, 32'h00500093, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 2'd0, 32'd0});
        v.push_back('{5'b01000, 32'h0, 32'h00500093, 32'h0, 5'b11100, 32'h0, 32'h00500093, 32'h4, 2'd0, 32'd0});
        v.push_back('{5'b00001, 32'h4, 32'h0, 32'h100, 5'b00010, 32'h0, 32'h0, 32'h0, 2'd0, 32'd0});
        v.push_back('{5'b00011, 32'h4, 32'h0, 32'h100, 5'b00110, 32'h0, 32'h0, 32'h100, 2'd0, 32'd0});
        v.push_back('{5'b00000, 32'h100, 32'h0, 32'h0, 5'b10000, 32'h100, 32'h0, 32'h0, 2'd0, 32'd1});
        v.push_back('{5'b00000, 32'h100, 32'h0, 32'h0, 5'b10000, 32'h100, 32'h0, 32'h0, 2'd0, 32'd1});
        v.push_back('{5'b00000, 32'h100, 32'h0, 32'h0, 5'b10000, 32'h100, 32'h0, 32'h0, 2'd0, 32'd1});
        v.push_back('{5'b01000, 32'h100, 32'hDEADBEEF, 32'h0, 5'b11100, 32'h100, 32'hDEADBEEF, 32'h104, 2'd0, 32'd1});
        v.push_back('{5'b00010, 32'h104, 32'h0, 32'h0, 5'b00010, 32'h0, 32'h0, 32'h0, 2'd0, 32'd1});
        v.push_back('{5'b01000, 32'hFFFFFFFC, 32'h13, 32'h0, 5'b11100, 32'hFFFFFFFC, 32'h13, 32'h0, 2'd0, 32'd2});
        v.push_back('{5'b00011, 32'h0, 32'h0, 32'h102, 5'b00010, 32'h0, 32'h0, 32'h0, 2'd0, 32'd2});
        v.push_back('{5'b01011, 32'h0, 32'h5, 32'h100, 5'b00001, 32'h0, 32'h0, 32'h0, 2'd3, 32'd2});
        v.push_back('{5'b10000, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 2'd0, 32'd0});
        v.push_back('{5'b01000, 32'h2, 32'h7, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 2'd0, 32'd0});
        v.push_back('{5'b01000, 32'h2, 32'h7, 32'h0, 5'b00001, 32'h0, 32'h0, 32'h0, 2'd1, 32'd0});
        v.push_back('{5'b10000, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 2'd0, 32'd0});
        v.push_back('{5'b01100, 32'h8, 32'h55, 32'h0, 5'b10000, 32'h8, 32'h0, 32'h0, 2'd0, 32'd0});
        v.push_back('{5'b01000, 32'h8, 32'h55, 32'h0, 5'b00001, 32'h0, 32'h0, 32'h0, 2'd2, 32'd0});
        v.push_back('{5'b10000, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 2'd0, 32'd0});
        v.push_back('{5'b00000, 32'h20, 32'h0, 32'h0, 5'b10000, 32'h20, 32'h0, 32'h0, 2'd0, 32'd0});
        v.push_back('{5'b10000, 32'h20, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 2'd0, 32'd0});
        v.push_back('{5'b00000, 32'h20, 32'h0, 32'h0, 5'b10000, 32'h20, 32'h0, 32'h0, 2'd0, 32'd0});
        v.push_back('{5'b01000, 32'h20, 32'h1234, 32'h0, 5'b11100, 32'h20, 32'h1234, 32'h24, 2'd0, 32'd0});

        foreach (v[i]) begin
            drive(v[i].ci, v[i].pc, v[i].rdata, v[i].tgt);
            act = {bus.mem_req, bus.ir_write_enable, bus.pc_write_enable, bus.instr_valid, bus.fault,
                   bus.mem_addr, bus.ir_data, bus.pc_next, bus.fault_cause, cnt32, cnt4};
            exp = {v[i].co, v[i].addr, v[i].ird, v[i].pcn, v[i].cause, v[i].cnt, v[i].cnt[3:0]};
            check($sformatf("row%0d", i), act, exp);
        end

        drive(5'b10000, 32'h0, 32'h0, 32'h0);
        exp_cnt = 32'd0;
        for (int i = 0; i < 16; i++) begin
            drive(5'b01000, 32'(i * 4), 32'h13, 32'h0);
            act = {163'd0, bus.ir_write_enable, cnt4};
            exp = {163'd0, 1'b1, exp_cnt[3:0]};
            check($sformatf("wrap_fetch%0d", i), act, exp);
            drive(5'b00010, 32'(i * 4 + 4), 32'h0, 32'h0);
            exp_cnt = exp_cnt + 32'd1;
        end
        drive(5'b00000, 32'h40, 32'h0, 32'h0);
        check("wrap_cnt32", {136'd0, cnt32}, {136'd0, exp_cnt});
        check("wrap_cnt4", {164'd0, cnt4}, {164'd0, 4'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
